// File: rtl/tl_source_allocator_if.sv
// Handshake and status bundle for the TileLink source-ID allocator.
// The slave modport is the allocator; the master modport is the adapter datapath driving it.
interface tl_source_allocator_if #(
  parameter int HostSourceWidth   = 4,
  parameter int DeviceSourceWidth = 2
);
  localparam int unsigned NumIds = 1 << DeviceSourceWidth;

  logic                         alloc_valid_i;
  logic                         alloc_ready_o;
  logic [HostSourceWidth-1:0]   alloc_host_source_i;
  logic [DeviceSourceWidth-1:0] alloc_id_o;
  logic                         free_valid_i;
  logic [DeviceSourceWidth-1:0] free_id_i;
  logic [DeviceSourceWidth-1:0] lookup_id_i;
  logic [HostSourceWidth-1:0]   lookup_source_o;
  logic                         drain_i;
  logic [NumIds-1:0]            busy_o;
  logic [DeviceSourceWidth:0]   count_o;
  logic                         full_o;
  logic                         idle_o;
  logic                         error_o;

  modport slave (
    input  alloc_valid_i, alloc_host_source_i, free_valid_i, free_id_i,
           lookup_id_i, drain_i,
    output alloc_ready_o, alloc_id_o, lookup_source_o, busy_o, count_o,
           full_o, idle_o, error_o
  );

  modport master (
    output alloc_valid_i, alloc_host_source_i, free_valid_i, free_id_i,
           lookup_id_i, drain_i,
    input  alloc_ready_o, alloc_id_o, lookup_source_o, busy_o, count_o,
           full_o, idle_o, error_o
  );
endinterface

// File: rtl/tl_source_allocator.sv
// Dynamic device source-ID allocator: grants the lowest free ID per request burst,
// remembers the host source against it, and releases it on the terminating D beat.
module tl_source_allocator #(
  parameter int HostSourceWidth   = 4,
  parameter int DeviceSourceWidth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tl_source_allocator_if.slave  bus
);
  localparam int unsigned NumIds = 1 << DeviceSourceWidth;
  localparam int          CntW   = DeviceSourceWidth + 1;

  logic [NumIds-1:0]            r_busy;
  logic [HostSourceWidth-1:0]   r_table [NumIds];
  logic [CntW-1:0]              r_count;
  logic                         r_err;

  logic [DeviceSourceWidth-1:0] w_alloc_id;
  logic                         w_found;
  logic                         w_full;
  logic                         w_ready;
  logic                         w_alloc_fire;
  logic                         w_free_legal;
  logic                         w_free_illegal;

  // Lowest clear bit of the registered busy vector; a same-cycle free is not seen here,
  // which is what keeps the granted ID distinct from free_id_i.
  always_comb begin
    w_alloc_id = '0;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (!r_busy[i] && !w_found) begin
        w_found    = 1'b1;
        w_alloc_id = DeviceSourceWidth'(i);
      end
    end
  end

  assign w_full         = (r_count == CntW'(NumIds));
  assign w_ready        = !w_full && !bus.drain_i;
  assign w_alloc_fire   = bus.alloc_valid_i && w_ready;
  assign w_free_legal   = bus.free_valid_i && r_busy[bus.free_id_i];
  assign w_free_illegal = bus.free_valid_i && !r_busy[bus.free_id_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < NumIds; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      if (w_alloc_fire) begin
        r_busy[w_alloc_id]  <= 1'b1;
        r_table[w_alloc_id] <= bus.alloc_host_source_i;
      end
      if (w_free_legal) begin
        r_busy[bus.free_id_i] <= 1'b0;
      end
      if (w_free_illegal) begin
        r_err <= 1'b1;
      end
      r_count <= r_count + CntW'(w_alloc_fire) - CntW'(w_free_legal);
    end
  end

  assign bus.alloc_ready_o   = w_ready;
  assign bus.alloc_id_o      = w_alloc_id;
  assign bus.lookup_source_o = r_table[bus.lookup_id_i];
  assign bus.busy_o          = r_busy;
  assign bus.count_o         = r_count;
  assign bus.full_o          = w_full;
  assign bus.idle_o          = (r_count == '0);
  assign bus.error_o         = r_err;
endmodule

// File: tb/tb_tl_source_allocator.sv
// Directed and randomized checks of tl_source_allocator against a simple pool model.
module tb_tl_source_allocator;
  localparam int HW = 4;
  localparam int DW = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_source_allocator_if #(.HostSourceWidth(HW), .DeviceSourceWidth(DW)) bus ();

  tl_source_allocator #(.HostSourceWidth(HW), .DeviceSourceWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference pool: a set of occupied IDs with their recorded host sources.
  bit          m_busy  [N];
  logic [HW-1:0] m_table [N];
  int          m_count;
  bit          m_err;

  function automatic int m_lowest();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  function automatic bit m_ready();
    return (m_count != N) && !bus.drain_i;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i]  = 1'b0;
      m_table[i] = '0;
    end
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready",  32'(bus.alloc_ready_o),   32'(m_ready()));
    chk("id",     32'(bus.alloc_id_o),      32'(m_lowest()));
    chk("busy",   32'(bus.busy_o),          m_busy_vec());
    chk("count",  32'(bus.count_o),         32'(m_count));
    chk("full",   32'(bus.full_o),          32'(m_count == N));
    chk("idle",   32'(bus.idle_o),          32'(m_count == 0));
    chk("error",  32'(bus.error_o),         32'(m_err));
    chk("lookup", 32'(bus.lookup_source_o), 32'(m_table[bus.lookup_id_i]));
  endtask

  task automatic drive(input bit av, input logic [HW-1:0] host, input bit fv, input logic [DW-1:0] fid);
    bus.alloc_valid_i       = av;
    bus.alloc_host_source_i = host;
    bus.free_valid_i        = fv;
    bus.free_id_i           = fid;
    #1;
  endtask

  // Advance one clock, applying the pool rules to the model from the inputs held at the edge.
  task automatic cycle();
    bit fire, fl, ill;
    int id;
    fire = bus.alloc_valid_i && m_ready();
    id   = m_lowest();
    fl   = bus.free_valid_i && m_busy[bus.free_id_i];
    ill  = bus.free_valid_i && !m_busy[bus.free_id_i];
    @(posedge clk);
    #1;
    if (fire) begin
      m_busy[id]  = 1'b1;
      m_table[id] = bus.alloc_host_source_i;
    end
    if (fl) m_busy[bus.free_id_i] = 1'b0;
    if (ill) m_err = 1'b1;
    m_count = m_count + int'(fire) - int'(fl);
  endtask

  logic [HW-1:0] hosts [4];

  initial begin
    hosts[0] = 4'hA; hosts[1] = 4'h3; hosts[2] = 4'hF; hosts[3] = 4'h7;
    rst = 1'b1;
    bus.drain_i     = 1'b0;
    bus.lookup_id_i = '0;
    m_reset();
    drive(1'b0, '0, 1'b0, '0);
    #1;
    check_all();
    chk("rst_ready", 32'(bus.alloc_ready_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Four back-to-back allocations fill the pool in order.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, hosts[k], 1'b0, '0);
      chk("fill_id", 32'(bus.alloc_id_o), 32'(k));
      check_all();
      cycle();
    end
    drive(1'b0, '0, 1'b0, '0);
    chk("fill_full",  32'(bus.full_o),        32'd1);
    chk("fill_ready", 32'(bus.alloc_ready_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus.lookup_id_i = DW'(k);
      #1;
      chk("fill_lookup", 32'(bus.lookup_source_o), 32'(hosts[k]));
    end

    // Free ID 2 while full, then re-grant it.
    drive(1'b0, '0, 1'b1, 2'd2);
    cycle();
    drive(1'b0, '0, 1'b0, '0);
    chk("refree_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("refree_id",    32'(bus.alloc_id_o),    32'd2);
    chk("refree_count", 32'(bus.count_o),       32'd3);
    drive(1'b1, 4'h5, 1'b0, '0);
    cycle();
    drive(1'b0, '0, 1'b0, '0);
    bus.lookup_id_i = 2'd2;
    #1;
    chk("realloc_lookup", 32'(bus.lookup_source_o), 32'h5);
    check_all();

    // Leave IDs 0 and 1 busy, then allocate and free ID 0 together.
    drive(1'b0, '0, 1'b1, 2'd2); cycle();
    drive(1'b0, '0, 1'b1, 2'd3); cycle();
    drive(1'b1, 4'h9, 1'b1, 2'd0);
    chk("simul_grant", 32'(bus.alloc_id_o), 32'd2);
    cycle();
    drive(1'b0, '0, 1'b0, '0);
    chk("simul_count", 32'(bus.count_o), 32'd2);
    chk("simul_busy",  32'(bus.busy_o),  32'b0110);
    chk("simul_lookup", 32'(bus.lookup_source_o), 32'h9);
    check_all();

    // Drain with three IDs busy while a request is held.
    drive(1'b1, 4'h1, 1'b0, '0); cycle();
    bus.drain_i = 1'b1;
    drive(1'b1, 4'h2, 1'b0, '0);
    chk("drain_ready", 32'(bus.alloc_ready_o), 32'd0);
    chk("drain_count", 32'(bus.count_o),       32'd3);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h2, 1'b1, DW'(k));
      check_all();
      cycle();
    end
    drive(1'b1, 4'h2, 1'b0, '0);
    chk("drain_idle",  32'(bus.idle_o),  32'd1);
    chk("drain_count0", 32'(bus.count_o), 32'd0);
    bus.drain_i = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    chk("drain_id0", 32'(bus.alloc_id_o), 32'd0);
    check_all();

    // Illegal free of idle ID 3 sets a sticky error.
    drive(1'b0, '0, 1'b1, 2'd3);
    chk("err_before", 32'(bus.error_o), 32'd0);
    cycle();
    drive(1'b0, '0, 1'b0, '0);
    chk("err_set",   32'(bus.error_o), 32'd1);
    chk("err_busy",  32'(bus.busy_o),  32'd0);
    chk("err_count", 32'(bus.count_o), 32'd0);
    cycle();
    chk("err_sticky", 32'(bus.error_o), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.drain_i     = ($urandom_range(7) == 0);
      bus.lookup_id_i = DW'($urandom_range(N - 1));
      drive(bit'($urandom_range(1)), HW'($urandom), ($urandom_range(2) == 0), DW'($urandom_range(N - 1)));
      check_all();
      cycle();
    end

    // Asynchronous reset between edges with state present.
    bus.drain_i = 1'b0;
    drive(1'b1, 4'hC, 1'b0, '0); cycle();
    drive(1'b0, '0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_error", 32'(bus.error_o), 32'd0);
    chk("arst_idle",  32'(bus.idle_o),  32'd1);
    m_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 4'h6, 1'b0, '0);
    chk("arst_id0", 32'(bus.alloc_id_o), 32'd0);
    cycle();
    drive(1'b0, '0, 1'b0, '0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tl_source_allocator.md
# tl_source_allocator

Dynamic source-ID allocator for TileLink source-width reduction. It maps wide host source IDs onto a pool of 2^DeviceSourceWidth device source IDs. The lowest free device ID is handed out at the start of each A/C request burst. The ID is returned when the terminating D beat completes. It replaces fixed low-bit truncation, so host IDs that share low bits no longer block each other. It sits beside the A/C/D datapath of a source-downsizing adapter, which drives its handshakes.

## Interface
Parameters:
- HostSourceWidth, 4, width of host-side source IDs.
- DeviceSourceWidth, 2, width of device-side IDs; NumIds = 2^DeviceSourceWidth.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- alloc_valid_i  in  1  request a device ID (asserted with the first beat of an A or C request).
- alloc_ready_o  out  1  an ID is available and allocation is permitted.
- alloc_host_source_i  in  HostSourceWidth  host source to record against the granted ID.
- alloc_id_o  out  DeviceSourceWidth  granted device ID, valid whenever alloc_ready_o=1.
- free_valid_i  in  1  release an ID (last D beat accepted).
- free_id_i  in  DeviceSourceWidth  ID to release.
- lookup_id_i  in  DeviceSourceWidth  device source of the current D beat.
- lookup_source_o  out  HostSourceWidth  host source recorded for lookup_id_i.
- drain_i  in  1  block new allocations; frees still proceed.
- busy_o  out  NumIds  per-ID occupancy vector.
- count_o  out  DeviceSourceWidth+1  number of busy IDs.
- full_o  out  1  count_o == NumIds.
- idle_o  out  1  count_o == 0.
- error_o  out  1  sticky protocol error flag.

## Operation
- State:
  - busy_q[NumIds]
  - table_q[NumIds][HostSourceWidth]
  - count_q
  - err_q
- Allocation:
  - alloc_ready_o = !full_o && !drain_i, computed from registered state only.
  - alloc_id_o = lowest index i with busy_q[i]=0 (priority encoder). It is 0 when full.
  - On alloc_valid_i && alloc_ready_o:
    - busy_q[alloc_id_o] is set.
    - table_q[alloc_id_o] captures alloc_host_source_i.
- Release:
  - A free is legal when busy_q[free_id_i]=1. On a legal free_valid_i, busy_q[free_id_i] is cleared; table_q is left unchanged.
  - A free of a non-busy ID is illegal. It causes no state change and sets err_q.
- Lookup: lookup_source_o = table_q[lookup_id_i], purely combinational. The value is meaningful only while that ID is busy.
- Count:
  - count_q next = count_q + alloc_fire - legal_free.
  - Width DeviceSourceWidth+1, so it never wraps.
  - busy_o = busy_q; full_o and idle_o are derived from count_q.
- Simultaneous alloc and free in one cycle:
  - Both take effect; count_q is unchanged.
  - The freed ID is not visible to the encoder until the next cycle.
  - The allocated ID always differs from free_id_i.
- drain_i: forces alloc_ready_o=0 in the same cycle. In-flight IDs still free normally. idle_o reports when drain is complete.
- err_q is cleared only by reset.

## Timing
- Reset (rst_i=1, asynchronous):
  - busy_q=0, table_q=0, count_q=0, err_q=0.
  - Outputs: busy_o=0, count_o=0, full_o=0, idle_o=1, error_o=0, alloc_id_o=0, lookup_source_o=0.
  - alloc_ready_o = !drain_i.
- Reset asserted mid-operation: all IDs are discarded immediately. The next allocation after release returns ID 0.
- Latency:
  - alloc_ready_o and alloc_id_o are combinational from state plus drain_i. They never depend on alloc_valid_i.
  - The allocation is visible in busy_o/count_o one cycle after the handshake.
  - A free is visible one cycle later; the freed ID can be re-granted in that cycle.
- Handshake: valid/ready. alloc_id_o is stable while alloc_valid_i is held and no free completes.
- lookup_source_o is zero-latency, so the D-channel response can be translated in the same cycle.

## Test plan
- Reset, then 4 back-to-back allocations with host sources 0xA, 0x3, 0xF, 0x7 (NumIds=4):
  - Required: IDs 0, 1, 2, 3; full_o=1 after the 4th; alloc_ready_o=0.
  - Lookup of IDs 0..3 returns 0xA, 0x3, 0xF, 0x7.
- While full:
  - Free ID 2 → next cycle alloc_ready_o=1, alloc_id_o=2, count_o=3.
  - Then allocate host source 0x5 → lookup_id_i=2 returns 0x5.
- With IDs 0 and 1 busy, in the same cycle allocate host source 0x9 and free ID 0:
  - Required: the grant is ID 2, not 0; count_o stays 2; busy_o=4'b0110.
- drain_i=1 with 3 IDs busy:
  - alloc_ready_o=0 immediately, while alloc_valid_i is held high.
  - Free all 3 IDs → idle_o=1 with count_o=0.
  - Deassert drain_i → alloc_id_o=0.
- Free ID 3 while it is not busy:
  - Required: error_o=1 from the next cycle and stays 1; busy_o and count_o are unchanged.
  - Assert rst_i mid-cycle → error_o=0 and idle_o=1 without waiting for a clock edge.
